// File: rtl/csr_mm_scheduler_if.sv
// Requester, engine and response signals of the CSR matmul job scheduler.
// slave = scheduler side, master = requesters/engine side.
interface csr_mm_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ),
    parameter int RES_W   = 144
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [SEL_W-1:0]   eng_sel;
    logic               eng_start;
    logic               eng_done;
    logic [RES_W-1:0]   eng_result;
    logic               eng_abort;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    logic [RES_W-1:0]   rsp_data;
    logic               rsp_error;
    logic               busy;
    logic [15:0]        job_count;

    modport slave (
        input  req_valid, eng_done, eng_result, rsp_ready,
        output req_ready, eng_sel, eng_start, eng_abort,
        output rsp_valid, rsp_data, rsp_error, busy, job_count
    );

    modport master (
        output req_valid, eng_done, eng_result, rsp_ready,
        input  req_ready, eng_sel, eng_start, eng_abort,
        input  rsp_valid, rsp_data, rsp_error, busy, job_count
    );
endinterface

// File: rtl/csr_mm_scheduler.sv
// Round-robin scheduler sharing one CSR sparse matmul engine among NUM_REQ requesters.
// Define CSR_MM_SCHED_TIMEOUT_EN to enable the WAIT watchdog (abort after TIMEOUT_CYCLES).
module csr_mm_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int SEL_W          = $clog2(NUM_REQ),
    parameter int RES_W          = 144,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              reset,
    csr_mm_scheduler_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] last_q;
    logic [SEL_W-1:0] eng_sel_q;
    logic [SEL_W-1:0] win_idx;
    logic             win_found;
    logic             accept;
    logic             rsp_hs;
    logic             timeout_hit;
    logic [RES_W-1:0] rsp_data_q;
    logic [15:0]      job_count_q;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("csr_mm_scheduler: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    // Rotating-priority scan starting just after the last served requester.
    always_comb begin
        logic [SEL_W:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_q} + (SEL_W+1)'(k);
            if (idx >= (SEL_W+1)'(NUM_REQ))
                idx = idx - (SEL_W+1)'(NUM_REQ);
            if (!win_found && bus.req_valid[idx[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[SEL_W-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && win_found;
    assign rsp_hs = (state_q == RESP) && bus.rsp_ready[eng_sel_q];

`ifdef CSR_MM_SCHED_TIMEOUT_EN
    logic [15:0] wait_cnt_q;
    logic        rsp_error_q;

    // eng_done in the timeout cycle wins, so the watchdog only fires without it.
    assign timeout_hit = (state_q == WAIT) && !bus.eng_done &&
                         (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt_q <= '0;
        else if (state_q == START)
            wait_cnt_q <= '0;
        else if (state_q == WAIT)
            wait_cnt_q <= wait_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            rsp_error_q <= 1'b0;
        else if (state_q == WAIT && bus.eng_done)
            rsp_error_q <= 1'b0;
        else if (timeout_hit)
            rsp_error_q <= 1'b1;
    end

    assign bus.rsp_error = rsp_error_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (bus.eng_done || timeout_hit) state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        bus.eng_start = 1'b0;
        bus.eng_abort = 1'b0;
        bus.rsp_valid = '0;
        bus.busy      = 1'b1;
        case (state_q)
            IDLE: begin
                bus.busy = 1'b0;
                if (win_found)
                    bus.req_ready = NUM_REQ'(1) << win_idx;
            end
            START:   bus.eng_start = 1'b1;
            WAIT:    bus.eng_abort = timeout_hit;
            RESP:    bus.rsp_valid = NUM_REQ'(1) << eng_sel_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q      <= SEL_W'(NUM_REQ - 1);
            eng_sel_q   <= '0;
            rsp_data_q  <= '0;
            job_count_q <= '0;
        end else begin
            if (accept)
                eng_sel_q <= win_idx;
            if (state_q == WAIT && bus.eng_done)
                rsp_data_q <= bus.eng_result;
            else if (timeout_hit)
                rsp_data_q <= '0;
            if (rsp_hs) begin
                last_q      <= eng_sel_q;
                job_count_q <= sat_inc16(job_count_q);
            end
        end
    end

    assign bus.eng_sel   = eng_sel_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.job_count = job_count_q;

endmodule

// File: tb/tb_csr_mm_scheduler.sv
// Directed and randomized bench for csr_mm_scheduler against a job-level reference model.
module tb_csr_mm_scheduler;
    localparam int NR = 4;
    localparam int SW = 2;
    localparam int RW = 144;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_last  = NR - 1;
    int   m_count = 0;
    int   rr_exp [5] = '{0, 1, 2, 3, 0};

    csr_mm_scheduler_if #(.NUM_REQ(NR), .SEL_W(SW), .RES_W(RW)) bus ();

    csr_mm_scheduler #(
        .NUM_REQ(NR), .SEL_W(SW), .RES_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, observed no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference rule: first requesting index after the last served one, wrapping.
    function automatic int model_winner(input logic [3:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [143:0] rand144();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[143:0];
    endfunction

    task automatic accept(input logic [3:0] vld, output int w);
        bus.req_valid = vld;
        settle();
        w = model_winner(vld, m_last);
        chk("grant", 160'(bus.req_ready), 160'(4'(1) << w));
        chk("busy_idle", 160'(bus.busy), 160'(0));
        tick();
        bus.req_valid = '0;
        settle();
        chk("start_pulse", 160'(bus.eng_start), 160'(1));
        chk("eng_sel", 160'(bus.eng_sel), 160'(w));
        chk("ready_start", 160'(bus.req_ready), 160'(0));
        chk("busy_start", 160'(bus.busy), 160'(1));
    endtask

    task automatic finish_resp(input int w, input logic [143:0] d, input logic e, input int bp);
        logic [3:0] oh;
        oh = 4'(1) << w;
        chk("rsp_valid", 160'(bus.rsp_valid), 160'(oh));
        chk("rsp_data", 160'(bus.rsp_data), 160'(d));
        chk("rsp_error", 160'(bus.rsp_error), 160'(e));
        chk("start_once", 160'(bus.eng_start), 160'(0));
        for (int c = 0; c < bp; c++) begin
            bus.rsp_ready = ~oh;
            bus.req_valid = 4'hF;
            tick();
            chk("bp_valid", 160'(bus.rsp_valid), 160'(oh));
            chk("bp_data", 160'(bus.rsp_data), 160'(d));
            chk("bp_req_ready", 160'(bus.req_ready), 160'(0));
            chk("bp_start", 160'(bus.eng_start), 160'(0));
        end
        bus.req_valid = '0;
        bus.rsp_ready = oh;
        tick();
        bus.rsp_ready = '0;
        settle();
        m_last = w;
        if (m_count < 65535) m_count++;
        chk("job_count", 160'(bus.job_count), 160'(m_count));
        chk("busy_after", 160'(bus.busy), 160'(0));
        chk("rsp_valid_after", 160'(bus.rsp_valid), 160'(0));
    endtask

    task automatic do_job(input logic [3:0] vld, input int lat, input logic [143:0] res,
                          input int bp, output int w);
        accept(vld, w);
        tick();
        for (int c = 1; c < lat; c++) begin
            chk("wait_start", 160'(bus.eng_start), 160'(0));
            chk("wait_rsp", 160'(bus.rsp_valid), 160'(0));
            chk("wait_abort", 160'(bus.eng_abort), 160'(0));
            tick();
        end
        bus.eng_done   = 1'b1;
        bus.eng_result = res;
        settle();
        chk("done_abort", 160'(bus.eng_abort), 160'(0));
        tick();
        bus.eng_done   = 1'b0;
        bus.eng_result = rand144();
        settle();
        finish_resp(w, res, 1'b0, bp);
    endtask

    initial begin
        int w;
        logic [143:0] r;
        logic [3:0] v;

        bus.req_valid  = '0;
        bus.eng_done   = 1'b0;
        bus.eng_result = '0;
        bus.rsp_ready  = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk("rst_req_ready", 160'(bus.req_ready), 160'(0));
        chk("rst_eng_sel", 160'(bus.eng_sel), 160'(0));
        chk("rst_eng_start", 160'(bus.eng_start), 160'(0));
        chk("rst_eng_abort", 160'(bus.eng_abort), 160'(0));
        chk("rst_rsp_valid", 160'(bus.rsp_valid), 160'(0));
        chk("rst_rsp_data", 160'(bus.rsp_data), 160'(0));
        chk("rst_rsp_error", 160'(bus.rsp_error), 160'(0));
        chk("rst_busy", 160'(bus.busy), 160'(0));
        chk("rst_job_count", 160'(bus.job_count), 160'(0));

        // Stray done while idle
        bus.eng_done   = 1'b1;
        bus.eng_result = rand144();
        tick();
        bus.eng_done = 1'b0;
        settle();
        chk("stray_busy", 160'(bus.busy), 160'(0));
        chk("stray_rsp_valid", 160'(bus.rsp_valid), 160'(0));
        chk("stray_job_count", 160'(bus.job_count), 160'(0));

        // Single job, done 10 cycles after start
        do_job(4'b0001, 10, 144'h1234, 0, w);
        chk("single_sel", 160'(bus.eng_sel), 160'(0));

        // Round-robin from a fresh reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last  = NR - 1;
        m_count = 0;
        for (int j = 0; j < 5; j++) begin
            do_job(4'hF, 2 + j, rand144(), 0, w);
            chk("rr_order", 160'(bus.eng_sel), 160'(rr_exp[j]));
        end

        // Response backpressure for 5 cycles
        do_job(4'hF, 3, rand144(), 5, w);
        chk("bp_sel", 160'(bus.eng_sel), 160'(1));

        // Reset three cycles after the start pulse
        accept(4'b0010, w);
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_busy", 160'(bus.busy), 160'(0));
        chk("midrst_eng_sel", 160'(bus.eng_sel), 160'(0));
        chk("midrst_rsp_data", 160'(bus.rsp_data), 160'(0));
        chk("midrst_rsp_valid", 160'(bus.rsp_valid), 160'(0));
        chk("midrst_eng_start", 160'(bus.eng_start), 160'(0));
        chk("midrst_job_count", 160'(bus.job_count), 160'(0));
        reset = 1'b0;
        m_last  = NR - 1;
        m_count = 0;
        bus.eng_done   = 1'b1;
        bus.eng_result = rand144();
        tick();
        bus.eng_done = 1'b0;
        settle();
        chk("late_done_busy", 160'(bus.busy), 160'(0));
        chk("late_done_rsp", 160'(bus.rsp_valid), 160'(0));
        chk("late_done_count", 160'(bus.job_count), 160'(0));

`ifdef CSR_MM_SCHED_TIMEOUT_EN
        // Done on the last allowed WAIT cycle beats the watchdog
        r = rand144();
        do_job(4'b0100, TO, r, 0, w);
        // No done at all: abort on the TO-th WAIT cycle
        accept(4'b1000, w);
        tick();
        for (int c = 1; c < TO; c++) begin
            chk("to_abort_early", 160'(bus.eng_abort), 160'(0));
            chk("to_rsp_early", 160'(bus.rsp_valid), 160'(0));
            tick();
        end
        chk("to_abort_pulse", 160'(bus.eng_abort), 160'(1));
        tick();
        chk("to_abort_once", 160'(bus.eng_abort), 160'(0));
        finish_resp(w, '0, 1'b1, 1);
`else
        accept(4'b1000, w);
        tick();
        repeat (40) tick();
        chk("nto_busy", 160'(bus.busy), 160'(1));
        chk("nto_abort", 160'(bus.eng_abort), 160'(0));
        chk("nto_rsp_valid", 160'(bus.rsp_valid), 160'(0));
        r = rand144();
        bus.eng_done   = 1'b1;
        bus.eng_result = r;
        tick();
        bus.eng_done = 1'b0;
        settle();
        finish_resp(w, r, 1'b0, 0);
`endif

        // Randomized jobs against the model
        for (int j = 0; j < 30; j++) begin
            v = 4'($urandom_range(1, 15));
            do_job(v, int'($urandom_range(1, TO - 1)), rand144(), int'($urandom_range(0, 3)), w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
